dbus_ctrl: RTL

- Memory-stage data-bus controller. Sits directly downstream of the store-alignment logic: consumes its aligned write data, byte strobe and misalignment flag, plus the load/store intent from the memory stage.
- Issues exactly one dbus transaction per memory instruction, stalls the pipeline until the transaction completes, and returns sign/zero-extended load data.
- Suppresses misaligned accesses and raises an exception instead.

---
 rtl/dbus_ctrl_pkg.sv | 12 +
 rtl/decode_pkg.sv | 13 +
 rtl/load_extract.sv | 33 +++
 rtl/dbus_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/dbus_ctrl_pkg.sv
// dbus_ctrl_pkg: pipeline-side types for the memory-stage data-bus controller.
// dbus_state_t: IDLE accepts a new access, BUSY owns the bus request,
// HOLD presents the completed result until the pipeline advances.
package dbus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } dbus_state_t;

endpackage

// File: rtl/decode_pkg.sv
// decode_pkg: shared decode-stage types.
// Provides the memory access size encoding used by the memory stage and the
// data bus (msize_t with MSIZE1/2/4/8 for byte/half/word/double accesses).
package decode_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

endpackage

// File: rtl/load_extract.sv
// load_extract: combinational load-data alignment and extension.
// Ports:
//   byte_off    - byte offset of the access within the bus lane (addr low bits)
//   msize       - access size (MSIZE1/2/4/8)
//   is_unsigned - zero-extend instead of sign-extend
//   raw         - full-lane read data from the bus
//   data        - right-justified, extended load value
module load_extract
    import decode_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [$clog2(DATA_W/8)-1:0] byte_off,
    input  msize_t                      msize,
    input  logic                        is_unsigned,
    input  logic [DATA_W-1:0]           raw,
    output logic [DATA_W-1:0]           data
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = raw >> {byte_off, 3'b000};
        data    = shifted;
        case (msize)
            MSIZE1: data = {{(DATA_W-8){shifted[7] & ~is_unsigned}},  shifted[7:0]};
            MSIZE2: data = {{(DATA_W-16){shifted[15] & ~is_unsigned}}, shifted[15:0]};
            MSIZE4: data = {{(DATA_W-32){shifted[31] & ~is_unsigned}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/dbus_ctrl.sv
// dbus_ctrl: memory-stage data-bus controller.
// Issues one bus transaction per memory instruction, stalls the pipeline until
// it completes, and returns extended load data. Misaligned accesses raise
// misalign_exc and never reach the bus.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   req_*                - memory-stage access (held stable while stall=1)
//   advance, flush       - pipeline register enable / kill current instruction
//   dreq_*               - bus request (registered, stable while dreq_valid)
//   dresp_data_ok/data   - bus completion pulse and raw read lane
//   done, rdata          - result available / extended load data (0 for stores)
//   stall, misalign_exc  - pipeline hold / misaligned-access exception
module dbus_ctrl
    import decode_pkg::*;
    import dbus_ctrl_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  msize_t              req_msize,
    input  logic                req_unsigned,
    input  logic [DATA_W-1:0]   req_wd,
    input  logic [DATA_W/8-1:0] req_strobe,
    input  logic                req_misalign,
    input  logic                advance,
    input  logic                flush,
    output logic                dreq_valid,
    output logic [ADDR_W-1:0]   dreq_addr,
    output msize_t              dreq_size,
    output logic [DATA_W/8-1:0] dreq_strobe,
    output logic [DATA_W-1:0]   dreq_data,
    input  logic                dresp_data_ok,
    input  logic [DATA_W-1:0]   dresp_data,
    output logic                done,
    output logic [DATA_W-1:0]   rdata,
    output logic                stall,
    output logic                misalign_exc
);

    localparam int OFF_W = $clog2(DATA_W/8);

    dbus_state_t       state;
    logic              write_r;
    logic              unsigned_r;
    logic              kill;
    logic              accept;
    logic [DATA_W-1:0] ext_data;

    assign accept       = (state == IDLE) && req_valid && !req_misalign && !flush;
    assign misalign_exc = (state == IDLE) && req_valid && req_misalign && !flush;
    // Stall starts in the accept cycle so the request stays on the inputs
    // until the bus registers have captured it.
    assign stall        = accept || (state == BUSY);

    load_extract #(.DATA_W(DATA_W)) u_load_extract (
        .byte_off    (dreq_addr[OFF_W-1:0]),
        .msize       (dreq_size),
        .is_unsigned (unsigned_r),
        .raw         (dresp_data),
        .data        (ext_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dreq_valid  <= 1'b0;
            dreq_addr   <= '0;
            dreq_size   <= MSIZE1;
            dreq_strobe <= '0;
            dreq_data   <= '0;
            write_r     <= 1'b0;
            unsigned_r  <= 1'b0;
            kill        <= 1'b0;
            done        <= 1'b0;
            rdata       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dreq_valid  <= 1'b1;
                        dreq_addr   <= req_addr;
                        dreq_size   <= req_msize;
                        dreq_strobe <= req_write ? req_strobe : '0;
                        dreq_data   <= req_wd;
                        write_r     <= req_write;
                        unsigned_r  <= req_unsigned;
                        kill        <= 1'b0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // A flushed transaction still runs to completion on the
                    // bus; kill only suppresses the result.
                    if (flush) begin
                        kill <= 1'b1;
                    end
                    if (dresp_data_ok) begin
                        dreq_valid <= 1'b0;
                        rdata      <= write_r ? '0 : ext_data;
                        if (kill || flush) begin
                            kill  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            done  <= 1'b1;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (advance || flush) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    dreq_valid <= 1'b0;
                    done       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
